// File: rtl/lsu_dmem_initiator.sv
// ============================================================================
// lsu_dmem_initiator : load/store initiator for the data-memory port.
// Optional build macro: LSU_TIMEOUT_EN (bounded WAIT with timeout error).
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_dmem_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic                  op_we,
  input  logic [1:0]            op_size,
  input  logic                  op_unsigned,
  input  logic [ADDR_WIDTH-1:0] op_addr,
  input  logic [DATA_WIDTH-1:0] op_wdata,
  input  logic [4:0]            op_rd,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_write_data,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic [3:0]            dmem_byte_enable,
  input  logic [DATA_WIDTH-1:0] dmem_read_data,
  input  logic                  dmem_ready,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [4:0]            res_rd,
  output logic                  res_misaligned,
  output logic                  res_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [1:0]            off_q, off_d;
  logic [4:0]            rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  res_valid_q, res_valid_d;
  logic                  res_mis_q, res_mis_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [4:0]            res_rd_q, res_rd_d;

  logic                  w_misaligned;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] w_load;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             res_err_q, res_err_d;
`endif

  assign w_misaligned = (op_size == 2'b11) ||
                        ((op_size == 2'b01) && op_addr[0]) ||
                        ((op_size == 2'b10) && (op_addr[1:0] != 2'b00));

  always_comb begin
    case (op_size)
      2'b00:   begin w_be = 4'b0001 << op_addr[1:0]; w_wdata = {(DATA_WIDTH/8){op_wdata[7:0]}};   end
      2'b01:   begin w_be = 4'b0011 << op_addr[1:0]; w_wdata = {(DATA_WIDTH/16){op_wdata[15:0]}}; end
      default: begin w_be = 4'b1111;                 w_wdata = op_wdata;                           end
    endcase
  end

  // Bring the addressed lane down to bit 0 before sign/zero extension.
  assign w_shifted = dmem_read_data >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   w_load = {{(DATA_WIDTH-8){~uns_q & w_shifted[7]}},   w_shifted[7:0]};
      2'b01:   w_load = {{(DATA_WIDTH-16){~uns_q & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    res_valid_d = 1'b0;
    res_mis_d   = 1'b0;
    res_data_d  = res_data_q;
    res_rd_d    = res_rd_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
    res_err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          we_d   = op_we;
          size_d = op_size;
          uns_d  = op_unsigned;
          off_d  = op_addr[1:0];
          rd_d   = op_rd;
          if (w_misaligned) begin
            state_d     = S_FAULT;
            res_valid_d = 1'b1;
            res_mis_d   = 1'b1;
            res_data_d  = '0;
            res_rd_d    = op_rd;
          end else begin
            state_d = S_REQ;
            addr_d  = {op_addr[ADDR_WIDTH-1:2], 2'b00};
            wdata_d = w_wdata;
            be_d    = w_be;
`ifdef LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (dmem_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b1;
          res_data_d  = we_q ? '0 : w_load;
          res_rd_d    = rd_q;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == C_TO_LAST) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
          res_data_d  = '0;
          res_rd_d    = rd_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      rd_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      res_valid_q <= 1'b0;
      res_mis_q   <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      res_valid_q <= res_valid_d;
      res_mis_q   <= res_mis_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      res_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      res_err_q <= res_err_d;
    end
  end
  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

  assign op_ready         = (state_q == S_IDLE);
  assign dmem_read        = (state_q == S_REQ) && !we_q;
  assign dmem_write       = (state_q == S_REQ) &&  we_q;
  assign dmem_addr        = addr_q;
  assign dmem_write_data  = wdata_q;
  assign dmem_byte_enable = be_q;
  assign res_valid        = res_valid_q;
  assign res_misaligned   = res_mis_q;
  assign res_data         = res_data_q;
  assign res_rd           = res_rd_q;

endmodule

`default_nettype wire

// File: doc/lsu_dmem_initiator.md
Name: lsu_dmem_initiator

Overview:
- Load/store initiator driving the data port of the memory subsystem: dmem_addr, dmem_write_data, dmem_read, dmem_write, dmem_byte_enable, dmem_read_data, dmem_ready.
- Accepts one load/store op at a time from the execute stage.
- Generates byte enables and lane-replicated write data, issues a one-cycle request pulse, and waits for dmem_ready.
- Returns sign/zero-extended load data, or an error, to writeback.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data word width (fixed 4 byte lanes)
TIMEOUT_CYCLES, 16, WAIT cycles before abort (used only with LSU_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
op_valid  input  1  op offered
op_ready  output  1  LSU can accept (high only in IDLE)
op_we  input  1  1=store, 0=load
op_size  input  2  00 byte, 01 half, 10 word, 11 illegal
op_unsigned  input  1  zero-extend load
op_addr  input  ADDR_WIDTH  byte address
op_wdata  input  DATA_WIDTH  store data (low bits significant)
op_rd  input  5  destination register tag
dmem_addr  output  ADDR_WIDTH  word-aligned request address (addr[1:0]=00)
dmem_write_data  output  DATA_WIDTH  lane-replicated store data
dmem_read  output  1  read request pulse
dmem_write  output  1  write request pulse
dmem_byte_enable  output  4  lane enables
dmem_read_data  input  DATA_WIDTH  memory read data
dmem_ready  input  1  memory completion
res_valid  output  1  one-cycle completion pulse
res_data  output  DATA_WIDTH  extended load data (0 for stores and errors)
res_rd  output  5  tag of completed op
res_misaligned  output  1  alignment/size fault, qualified by res_valid
res_err  output  1  timeout fault, qualified by res_valid

Behaviour:
- Reset: state IDLE; all request outputs 0; dmem_addr/dmem_write_data/dmem_byte_enable 0; res_* 0; op_ready 1.
- Reset mid-operation aborts the op. No further request is issued. A late dmem_ready is ignored.
- States:
  - IDLE: op_ready=1. On op_valid, latch op fields. Misaligned if half with addr[0]=1, word with addr[1:0]!=0, or size 11 → go to FAULT. Otherwise → REQ.
  - REQ: exactly one cycle. dmem_read=!we, dmem_write=we. Address and data outputs valid. → WAIT.
  - WAIT: request outputs 0; address/data outputs hold. On dmem_ready: capture and extend data, pulse res_valid next cycle, → IDLE.
  - FAULT: one cycle. res_valid=1, res_misaligned=1, res_data=0. No memory request. → IDLE.
- Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
- Write data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load extract: shifted = dmem_read_data >> (8*addr[1:0]). Byte/half take low 8/16 bits, sign-extended unless op_unsigned.
- Stores complete with res_valid=1, res_data=0, res_rd=latched rd.
- Latency (nominal memory with 1-cycle ready): accept edge E0; cycle 1 request; cycle 2 dmem_ready; cycle 3 res_valid and op_ready=1. Next op can be accepted in cycle 3. Fault latency: res_valid in cycle 1.
- dmem_ready outside WAIT is ignored. dmem_ready in the same cycle as REQ is ignored.
- res_valid is a single-cycle pulse. res_misaligned and res_err are never both 1.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: a counter clears on REQ entry and increments each WAIT cycle. If it reaches TIMEOUT_CYCLES without dmem_ready, the op completes with res_valid=1, res_err=1, res_data=0, → IDLE. dmem_ready in the same cycle as timeout wins (normal completion).
- Undefined: WAIT holds indefinitely; res_err tied 0; no counter logic.

Test Plan:
- Signed byte load, addr 0x103, memory word 0x80FF_1234 → dmem_addr 0x100, BE 1000, dmem_read pulsed 1 cycle; res_data 0xFFFF_FF80, res_valid 3 cycles after accept.
- Unsigned half load, addr 0x202, word 0xBEEF_0000 → BE 1100, res_data 0x0000_BEEF. Repeat signed → 0xFFFF_BEEF.
- Byte store, addr 0x101, wdata 0x0000_00AB → dmem_write pulse, BE 0010, dmem_write_data 0xABAB_ABAB; res_valid with res_data 0.
- Word load at addr 0x0006 and op_size 11 → no dmem_read/dmem_write; res_valid next cycle with res_misaligned=1.
- Memory stub delays ready 5 cycles → op_ready low throughout, single request pulse, completion on ready. With LSU_TIMEOUT_EN and ready never asserted → res_err=1 after 16 WAIT cycles.
- Assert rst_n low during WAIT, then deassert and drive a late dmem_ready → outputs at reset values, no res_valid, op_ready=1.
